vram_arbiter: RTL

Single-port VRAM access controller between the display scan-out reader and the CPU-side VRAM write FIFO. It grants one transaction at a time to the external synchronous VRAM port using a req/ack handshake, and pops the write FIFO only after the memory acknowledges the write. Display reads have priority, and a streak limit guarantees the FIFO drains.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_arb_watchdog.sv | 29 ++
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM definitions: default bus widths, arbiter FSM states and streak helper.
package vram_pkg;

  localparam int VRAM_DATA_WIDTH    = 16;
  localparam int VRAM_ADDRESS_WIDTH = 16;
  localparam int STREAK_WIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

  // Saturating increment so the read streak can never wrap past the limit.
  function automatic logic [STREAK_WIDTH-1:0] streak_inc(
    input logic [STREAK_WIDTH-1:0] streak,
    input logic [STREAK_WIDTH-1:0] limit
  );
    return (streak >= limit) ? limit : streak + 1'b1;
  endfunction

endpackage

// File: rtl/vram_arb_watchdog.sv
// Ack-wait counter: counts while enabled, flags expiry on the last allowed cycle.
module vram_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   LP_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && (r_count == LP_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads vs. write-FIFO drain with a read-streak limit.
// Optional ack watchdog and sticky error flag are enabled by VRAM_ARB_TIMEOUT_EN.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_WIDTH      = VRAM_DATA_WIDTH,
  parameter int ADDRESS_WIDTH   = VRAM_ADDRESS_WIDTH,
  parameter int MAX_READ_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     display_req,
  input  logic [ADDRESS_WIDTH-1:0] display_address,
  output logic                     display_ready,
  output logic [DATA_WIDTH-1:0]    display_data,
  input  logic                     fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0] fifo_read_address,
  input  logic [DATA_WIDTH-1:0]    fifo_read_data,
  output logic                     fifo_read_request,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     busy,
  output logic                     error
);

  localparam logic [STREAK_WIDTH-1:0] LP_STREAK_MAX = STREAK_WIDTH'(MAX_READ_STREAK);

  arb_state_t                r_state;
  arb_state_t                w_state_next;
  logic [STREAK_WIDTH-1:0]   r_streak;
  logic                      r_mem_req;
  logic                      r_mem_we;
  logic [ADDRESS_WIDTH-1:0]  r_mem_address;
  logic [DATA_WIDTH-1:0]     r_mem_wdata;
  logic                      r_display_ready;
  logic [DATA_WIDTH-1:0]     r_display_data;
  logic                      w_read_win;
  logic                      w_read_done;
  logic                      w_fifo_pop;
  logic                      w_busy;
  logic                      w_timeout;
  logic                      w_grant;
  logic                      w_release;

  // Display wins unless writes are pending and the streak has hit its limit.
  assign w_read_win = display_req && (fifo_empty || (r_streak < LP_STREAK_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_read_win) begin
          w_state_next = READ;
        end else if (!fifo_empty) begin
          w_state_next = WRITE;
        end
      end
      READ, WRITE: begin
        if (mem_ack || w_timeout) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != IDLE);
    w_read_done = (r_state == READ) && mem_ack;
    w_fifo_pop  = (r_state == WRITE) && mem_ack;
    w_grant     = (r_state == IDLE) && (w_state_next != IDLE);
    w_release   = (r_state != IDLE) && (w_state_next == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_address   <= '0;
      r_mem_wdata     <= '0;
      r_display_ready <= 1'b0;
      r_display_data  <= '0;
      r_streak        <= '0;
    end else begin
      r_display_ready <= w_read_done;
      if (w_read_done) begin
        r_display_data <= mem_rdata;
      end
      if (w_grant) begin
        r_mem_req     <= 1'b1;
        r_mem_we      <= (w_state_next == WRITE);
        r_mem_address <= (w_state_next == WRITE) ? fifo_read_address : display_address;
        r_mem_wdata   <= (w_state_next == WRITE) ? fifo_read_data : '0;
      end else if (w_release) begin
        r_mem_req <= 1'b0;
      end
      if (w_read_done) begin
        r_streak <= fifo_empty ? '0 : streak_inc(r_streak, LP_STREAK_MAX);
      end else if (w_fifo_pop) begin
        r_streak <= '0;
      end
    end
  end

`ifdef VRAM_ARB_TIMEOUT_EN
  logic r_error;

  vram_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  ((r_state == IDLE) || mem_ack),
    .i_enable (w_busy && !mem_ack),
    .o_expired(w_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign error            = 1'b0;
`endif

  assign display_ready     = r_display_ready;
  assign display_data      = r_display_data;
  assign fifo_read_request = w_fifo_pop;
  assign mem_req           = r_mem_req;
  assign mem_we            = r_mem_we;
  assign mem_address       = r_mem_address;
  assign mem_wdata         = r_mem_wdata;
  assign busy              = w_busy;

endmodule
